// File: rtl/cache_if_pkg.sv
// ----------------------------------------------------------------------------
// cache_if_pkg
//   Shared definitions for the cache refill/writeback port. Imported by the
//   data cache and by the memory-side responder so both ends agree on the
//   request type codes, the line geometry and the FSM state encodings.
//
//   Contents:
//     RD_TYPE_LINE / WR_TYPE_LINE : request type code for a 4-word line
//     LINE_WORDS                  : 32-bit words per cache line
//     rd_state_t / wr_state_t     : responder read / write FSM states
//     last_beat()                 : index of the final word of a transfer
// ----------------------------------------------------------------------------
package cache_if_pkg;

    localparam logic [2:0] RD_TYPE_LINE = 3'b100;
    localparam logic [2:0] WR_TYPE_LINE = 3'b100;
    localparam int         LINE_WORDS   = 4;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_SEND = 2'd2
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_t;

    // A line moves words 0..LINE_WORDS-1; anything else moves word 0 only.
    function automatic logic [1:0] last_beat(input logic is_line);
        return is_line ? 2'(LINE_WORDS - 1) : 2'd0;
    endfunction

endpackage

// File: rtl/resp_word_ram.sv
// ----------------------------------------------------------------------------
// resp_word_ram
//   2^ADDR_W x 32-bit word RAM backing the cache memory responder.
//   One synchronous write port with per-byte enables, one asynchronous
//   (combinational) read port. Contents are never reset.
//
//   Ports:
//     i_clk   : clock
//     i_we    : write enable
//     i_waddr : write word index
//     i_wstrb : byte enables for i_wdata (bit b covers [8b+7:8b])
//     i_wdata : write data
//     i_raddr : read word index
//     o_rdata : read data, follows i_raddr within the cycle
// ----------------------------------------------------------------------------
module resp_word_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [3:0]        i_wstrb,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    // NOTE: storage arrays get no reset branch; resetting every word would
    // turn the RAM into a huge flop bank, and contents must survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cache_mem_responder.sv
// ----------------------------------------------------------------------------
// cache_mem_responder
//   Memory-side end of the data cache refill/writeback port. Serves 4-beat
//   line reads and single-word reads, and absorbs line writebacks and
//   single-word writes into a local word-addressed RAM (resp_word_ram).
//
//   Parameters:
//     ADDR_W : word-index bits, RAM holds 2^ADDR_W words (addresses alias)
//     RD_LAT : cycles from read acceptance to first ret_valid (1..15)
//
//   Ports:
//     clk_g, resetn              : clock, asynchronous active-low reset
//     rd_req/rd_type/rd_addr     : read request (type 3'b100 = line)
//     rd_rdy                     : read accepted this cycle when rd_req=1
//     ret_valid/ret_last/ret_data: read return beats, one per cycle
//     wr_req/wr_type/wr_addr     : write request (type 3'b100 = line)
//     wr_wstrb/wr_data           : byte enables (every word), 128-bit data
//     wr_rdy                     : write accepted this cycle when wr_req=1
// ----------------------------------------------------------------------------
module cache_mem_responder
    import cache_if_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic         clk_g,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    // ------------------------------------------------------------------
    // Write side state
    // ------------------------------------------------------------------
    wr_state_t         r_wr_state;
    logic              r_wr_rdy;
    logic              r_wr_line;
    logic [ADDR_W-1:0] r_wr_idx;    // base word index (low bits 0 for lines)
    logic [3:0]        r_wr_strb;
    logic [127:0]      r_wr_data;
    logic [1:0]        r_wr_cnt;    // word being committed

    // ------------------------------------------------------------------
    // Read side state
    // ------------------------------------------------------------------
    rd_state_t         r_rd_state;
    logic              r_rd_rdy;
    logic              r_rd_line;
    logic [ADDR_W-1:0] r_rd_idx;
    logic [1:0]        r_beat;      // word offset of the next beat to load
    logic [3:0]        r_lat_cnt;
    logic              r_ret_valid;
    logic              r_ret_last;
    logic [31:0]       r_ret_data;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              w_wr_accept;
    logic              w_wr_req_line;
    logic [ADDR_W-1:0] w_wr_req_idx;
    logic              w_rd_rdy;
    logic              w_rd_accept;
    logic              w_rd_req_line;
    logic [ADDR_W-1:0] w_rd_req_idx;

    assign w_wr_accept   = wr_req && r_wr_rdy;
    assign w_wr_req_line = (wr_type == WR_TYPE_LINE);
    assign w_wr_req_idx  = w_wr_req_line ? {wr_addr[ADDR_W+1:4], 2'b00}
                                         : wr_addr[ADDR_W+1:2];

    // Reads yield to writes: a pending or in-flight write holds reads off
    // so that any read accepted afterwards observes the completed write.
    assign w_rd_rdy      = r_rd_rdy && !wr_req && (r_wr_state == W_IDLE);
    assign w_rd_accept   = rd_req && w_rd_rdy;
    assign w_rd_req_line = (rd_type == RD_TYPE_LINE);
    assign w_rd_req_idx  = w_rd_req_line ? {rd_addr[ADDR_W+1:4], 2'b00}
                                         : rd_addr[ADDR_W+1:2];

    // Address bits outside the word index are ignored by design.
    logic w_unused;
    assign w_unused = &{1'b0, rd_addr[31:ADDR_W+2], rd_addr[1:0],
                        wr_addr[31:ADDR_W+2], wr_addr[1:0]};

    // ------------------------------------------------------------------
    // RAM ports
    // ------------------------------------------------------------------
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [31:0]       w_ram_wdata;
    logic              w_cur_line;
    logic [ADDR_W-1:0] w_cur_idx;
    logic [ADDR_W-1:0] w_ram_raddr;
    logic [31:0]       w_ram_rdata;

    assign w_ram_we    = (r_wr_state == W_BUSY);
    assign w_ram_waddr = {r_wr_idx[ADDR_W-1:2], r_wr_idx[1:0] | r_wr_cnt};
    assign w_ram_wdata = r_wr_data[32*r_wr_cnt +: 32];

    // While idle the request is not latched yet; with RD_LAT=1 the first
    // beat is fetched in the acceptance cycle straight from the inputs.
    assign w_cur_line  = (r_rd_state == R_IDLE) ? w_rd_req_line : r_rd_line;
    assign w_cur_idx   = (r_rd_state == R_IDLE) ? w_rd_req_idx  : r_rd_idx;
    assign w_ram_raddr = {w_cur_idx[ADDR_W-1:2], w_cur_idx[1:0] | r_beat};

    resp_word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (clk_g),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wstrb (r_wr_strb),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Write FSM: latch on acceptance, then commit one word per cycle.
    // ------------------------------------------------------------------
    // NOTE: state flops use non-blocking assignments and an asynchronous
    // active-low reset, so every register updates together at the edge.
    always_ff @(posedge clk_g or negedge resetn) begin
        if (!resetn) begin
            r_wr_state <= W_IDLE;
            r_wr_rdy   <= 1'b0;
            r_wr_line  <= 1'b0;
            r_wr_idx   <= '0;
            r_wr_strb  <= 4'h0;
            r_wr_data  <= '0;
            r_wr_cnt   <= 2'd0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_wr_accept) begin
                        r_wr_state <= W_BUSY;
                        r_wr_rdy   <= 1'b0;
                        r_wr_line  <= w_wr_req_line;
                        r_wr_idx   <= w_wr_req_idx;
                        r_wr_strb  <= wr_wstrb;
                        r_wr_data  <= wr_data;
                        r_wr_cnt   <= 2'd0;
                    end else begin
                        r_wr_rdy   <= 1'b1;
                    end
                end
                W_BUSY: begin
                    // Word r_wr_cnt is written by the RAM at this edge.
                    if (r_wr_cnt == last_beat(r_wr_line)) begin
                        r_wr_state <= W_IDLE;
                        r_wr_rdy   <= 1'b1;
                    end else begin
                        r_wr_cnt   <= r_wr_cnt + 2'd1;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                    r_wr_rdy   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read FSM. A beat is "loaded" one cycle before it is presented:
    // ret_data captures the RAM word and ret_valid rises at that edge.
    // ------------------------------------------------------------------
    logic w_load;

    assign w_load = ((r_rd_state == R_IDLE) && w_rd_accept && (RD_LAT == 1)) ||
                    ((r_rd_state == R_WAIT) && (r_lat_cnt == 4'd1))          ||
                    ((r_rd_state == R_SEND) && !r_ret_last);

    always_ff @(posedge clk_g or negedge resetn) begin
        if (!resetn) begin
            r_rd_state  <= R_IDLE;
            r_rd_rdy    <= 1'b0;
            r_rd_line   <= 1'b0;
            r_rd_idx    <= '0;
            r_beat      <= 2'd0;
            r_lat_cnt   <= 4'd0;
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_data  <= 32'h0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_rd_accept) begin
                        r_rd_rdy  <= 1'b0;
                        r_rd_line <= w_rd_req_line;
                        r_rd_idx  <= w_rd_req_idx;
                        r_lat_cnt <= 4'(RD_LAT - 1);
                        r_rd_state <= (RD_LAT == 1) ? R_SEND : R_WAIT;
                    end else begin
                        r_rd_rdy  <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_lat_cnt == 4'd1) begin
                        r_rd_state <= R_SEND;
                    end else begin
                        r_lat_cnt  <= r_lat_cnt - 4'd1;
                    end
                end
                R_SEND: begin
                    // The final beat is on the bus this cycle: close out.
                    if (r_ret_last) begin
                        r_rd_state  <= R_IDLE;
                        r_rd_rdy    <= 1'b1;
                        r_ret_valid <= 1'b0;
                        r_ret_last  <= 1'b0;
                        r_beat      <= 2'd0;
                    end
                end
                default: begin
                    r_rd_state  <= R_IDLE;
                    r_rd_rdy    <= 1'b0;
                    r_ret_valid <= 1'b0;
                    r_ret_last  <= 1'b0;
                    r_beat      <= 2'd0;
                end
            endcase

            // ret_data only changes on a load, so it holds between bursts.
            if (w_load) begin
                r_ret_valid <= 1'b1;
                r_ret_data  <= w_ram_rdata;
                r_ret_last  <= (r_beat == last_beat(w_cur_line));
                if (r_beat != last_beat(w_cur_line)) begin
                    r_beat <= r_beat + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_rdy    = w_rd_rdy;
    assign wr_rdy    = r_wr_rdy;
    assign ret_valid = r_ret_valid;
    assign ret_last  = r_ret_last;
    assign ret_data  = r_ret_data;

endmodule

// File: tb/tb_cache_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_cache_mem_responder
//   Directed bench for cache_mem_responder (ADDR_W=10, RD_LAT=2). Inputs
//   change 1ns after the rising edge; outputs are sampled on the falling
//   edge. Cycle numbers in the scenarios are relative to the accepting edge.
// ----------------------------------------------------------------------------
module tb_cache_mem_responder;

    localparam int ADDR_W = 10;
    localparam int RD_LAT = 2;
    localparam int WAIT_BOUND = 30;

    logic         clk_g = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the most recent read, filled by collect_read.
    int          rb_acc_wait;
    int          rb_first;
    int          rb_n;
    int          rb_last_at;
    int          rb_last_cnt;
    int          rb_rdy_back;
    bit          rb_gap;
    logic [31:0] rb_beats [4];

    always #5 clk_g = ~clk_g;

    cache_mem_responder #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk_g     (clk_g),
        .resetn    (resetn),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // ---------------------------------------------------------------- helpers
    // Issue a write, wait (bounded) for acceptance, then count the cycles
    // wr_rdy stays low. Returns on the falling edge where wr_rdy is high.
    task automatic do_write(input logic [2:0] t, input logic [31:0] a,
                            input logic [3:0] s, input logic [127:0] d,
                            output int acc_wait, output int low_cycles);
        @(posedge clk_g); #1;
        wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
        acc_wait = 0;
        @(negedge clk_g);
        while (!wr_rdy && acc_wait < WAIT_BOUND) begin
            @(negedge clk_g); acc_wait++;
        end
        @(posedge clk_g); #1;
        wr_req = 1'b0;
        low_cycles = 0;
        @(negedge clk_g);
        while (!wr_rdy && low_cycles < WAIT_BOUND) begin
            low_cycles++; @(negedge clk_g);
        end
    endtask

    // rd_req is already driven: wait for acceptance, drop the request and
    // record the return beats until rd_rdy comes back.
    task automatic collect_read();
        rb_acc_wait = 0; rb_first = -1; rb_n = 0; rb_last_at = -1;
        rb_last_cnt = 0; rb_rdy_back = -1; rb_gap = 1'b0;
        for (int i = 0; i < 4; i++) rb_beats[i] = 'x;
        @(negedge clk_g);
        while (!rd_rdy && rb_acc_wait < WAIT_BOUND) begin
            @(negedge clk_g); rb_acc_wait++;
        end
        @(posedge clk_g); #1;
        rd_req = 1'b0;
        for (int c = 1; c <= RD_LAT + 10 && rb_rdy_back < 0; c++) begin
            @(negedge clk_g);
            if (ret_valid) begin
                if (rb_first < 0) rb_first = c;
                if (c != rb_first + rb_n) rb_gap = 1'b1;
                if (rb_n < 4) rb_beats[rb_n] = ret_data;
                rb_n++;
            end
            if (ret_last) begin
                rb_last_cnt++;
                rb_last_at = c;
                if (!ret_valid) rb_gap = 1'b1;
            end
            if (rd_rdy) rb_rdy_back = c;
        end
    endtask

    task automatic do_read(input logic [2:0] t, input logic [31:0] a);
        @(posedge clk_g); #1;
        rd_req = 1'b1; rd_type = t; rd_addr = a;
        collect_read();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        resetn = 1'b0;
        rd_req = 1'b0; rd_type = 3'b000; rd_addr = 32'h0;
        wr_req = 1'b0; wr_type = 3'b000; wr_addr = 32'h0;
        wr_wstrb = 4'h0; wr_data = '0;
        #12;
        n_tests++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rd_rdy: got %b want 0", rd_rdy); end
        n_tests++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_wr_rdy: got %b want 0", wr_rdy); end
        n_tests++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ret_valid: got %b want 0", ret_valid); end
        n_tests++; if (ret_last !== 1'b0) begin n_fail++; $display("FAIL reset_ret_last: got %b want 0", ret_last); end
        n_tests++; if (ret_data !== 32'h0) begin n_fail++; $display("FAIL reset_ret_data: got %h want 0", ret_data); end
        @(negedge clk_g);
        resetn = 1'b1;
        #1;
        n_tests++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL rel_rd_rdy_before_edge: got %b want 0", rd_rdy); end
        @(negedge clk_g);
        n_tests++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_rd_rdy_first_edge: got %b want 1", rd_rdy); end
        n_tests++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_wr_rdy_first_edge: got %b want 1", wr_rdy); end
    endtask

    task automatic test_line_write_read();
        logic [31:0] d [4];
        int aw, low;
        d[0] = 32'hA0A0_0000; d[1] = 32'hA1A1_1111;
        d[2] = 32'hA2A2_2222; d[3] = 32'hA3A3_3333;
        do_write(3'b100, 32'h0000_0040, 4'hF, {d[3], d[2], d[1], d[0]}, aw, low);
        n_tests++; if (aw !== 0) begin n_fail++; $display("FAIL line_wr_accept_wait: got %0d want 0", aw); end
        n_tests++; if (low !== 4) begin n_fail++; $display("FAIL line_wr_rdy_low: got %0d cycles want 4", low); end
        do_read(3'b100, 32'h0000_004C);
        n_tests++; if (rb_acc_wait !== 0) begin n_fail++; $display("FAIL line_rd_accept_wait: got %0d want 0", rb_acc_wait); end
        n_tests++; if (rb_first !== RD_LAT) begin n_fail++; $display("FAIL line_rd_first_beat: got %0d want %0d", rb_first, RD_LAT); end
        n_tests++; if (rb_n !== 4) begin n_fail++; $display("FAIL line_rd_beats: got %0d want 4", rb_n); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rb_beats[i] !== d[i]) begin n_fail++; $display("FAIL line_rd_data[%0d]: got %h want %h", i, rb_beats[i], d[i]); end
        end
        n_tests++; if (rb_last_at !== RD_LAT + 3) begin n_fail++; $display("FAIL line_rd_last_at: got %0d want %0d", rb_last_at, RD_LAT + 3); end
        n_tests++; if (rb_last_cnt !== 1) begin n_fail++; $display("FAIL line_rd_last_count: got %0d want 1", rb_last_cnt); end
        n_tests++; if (rb_gap !== 1'b0) begin n_fail++; $display("FAIL line_rd_gap: got %b want 0", rb_gap); end
        n_tests++; if (rb_rdy_back !== RD_LAT + 4) begin n_fail++; $display("FAIL line_rd_rdy_back: got %0d want %0d", rb_rdy_back, RD_LAT + 4); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] e [4];
        e[0] = 32'hE000_0E00; e[1] = 32'hE111_1E11;
        e[2] = 32'hE222_2E22; e[3] = 32'hE333_3E33;
        @(posedge clk_g); #1;
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_0080;
        wr_wstrb = 4'hF; wr_data = {e[3], e[2], e[1], e[0]};
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0080;
        @(negedge clk_g);
        n_tests++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL same_wr_rdy: got %b want 1", wr_rdy); end
        n_tests++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL same_rd_rdy_blocked: got %b want 0", rd_rdy); end
        @(posedge clk_g); #1;
        wr_req = 1'b0;
        collect_read();
        // Read held low in T+1..T+4, accepted at T+5.
        n_tests++; if (rb_acc_wait !== 4) begin n_fail++; $display("FAIL same_rd_accept_wait: got %0d want 4", rb_acc_wait); end
        n_tests++; if (rb_first !== RD_LAT) begin n_fail++; $display("FAIL same_rd_first_beat: got %0d want %0d", rb_first, RD_LAT); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rb_beats[i] !== e[i]) begin n_fail++; $display("FAIL same_rd_data[%0d]: got %h want %h", i, rb_beats[i], e[i]); end
        end
        n_tests++; if (rb_last_at !== RD_LAT + 3) begin n_fail++; $display("FAIL same_rd_last_at: got %0d want %0d", rb_last_at, RD_LAT + 3); end
    endtask

    task automatic test_byte_strobe();
        int aw, low;
        do_write(3'b000, 32'h0000_0084, 4'hF, {96'h0, 32'h1122_3344}, aw, low);
        n_tests++; if (low !== 1) begin n_fail++; $display("FAIL word_wr_rdy_low: got %0d want 1", low); end
        do_write(3'b001, 32'h0000_0084, 4'b0010, {96'h0, 32'hAABB_CCDD}, aw, low);
        n_tests++; if (aw !== 0 || low !== 1) begin n_fail++; $display("FAIL strb_wr_timing: got wait %0d low %0d want 0/1", aw, low); end
        do_read(3'b000, 32'h0000_0084);
        n_tests++; if (rb_n !== 1) begin n_fail++; $display("FAIL strb_rd_beats: got %0d want 1", rb_n); end
        n_tests++; if (rb_beats[0] !== 32'h1122_CC44) begin n_fail++; $display("FAIL strb_rd_data: got %h want 1122cc44", rb_beats[0]); end
        n_tests++; if (rb_first !== RD_LAT || rb_last_at !== RD_LAT) begin n_fail++; $display("FAIL strb_rd_valid_last: got first %0d last %0d want %0d/%0d", rb_first, rb_last_at, RD_LAT, RD_LAT); end
        n_tests++; if (rb_rdy_back !== RD_LAT + 1) begin n_fail++; $display("FAIL strb_rd_rdy_back: got %0d want %0d", rb_rdy_back, RD_LAT + 1); end
    endtask

    task automatic test_zero_strobe();
        int aw, low;
        do_write(3'b000, 32'h0000_0084, 4'h0, {96'h0, 32'hDEAD_BEEF}, aw, low);
        n_tests++; if (aw !== 0 || low !== 1) begin n_fail++; $display("FAIL zstrb_wr_timing: got wait %0d low %0d want 0/1", aw, low); end
        // Unlisted type code 3'b111 must behave as a single-word read.
        do_read(3'b111, 32'h0000_0084);
        n_tests++; if (rb_n !== 1) begin n_fail++; $display("FAIL zstrb_rd_beats: got %0d want 1", rb_n); end
        n_tests++; if (rb_beats[0] !== 32'h1122_CC44) begin n_fail++; $display("FAIL zstrb_rd_data: got %h want 1122cc44", rb_beats[0]); end
    endtask

    task automatic test_alias();
        int aw, low;
        do_write(3'b010, 32'h0000_1000, 4'hF, {96'h0, 32'hCAFE_F00D}, aw, low);
        do_read(3'b001, 32'h0000_0000);
        n_tests++; if (rb_beats[0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL alias_rd_data: got %h want cafef00d", rb_beats[0]); end
        n_tests++; if (rb_last_cnt !== 1) begin n_fail++; $display("FAIL alias_rd_last_count: got %0d want 1", rb_last_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] f [4];
        logic [31:0] b1;
        int aw, low, seen, cyc, stale;
        f[0] = 32'hF0F0_0F00; f[1] = 32'hF1F1_1F11;
        f[2] = 32'hF2F2_2F22; f[3] = 32'hF3F3_3F33;
        do_write(3'b100, 32'h0000_0100, 4'hF, {f[3], f[2], f[1], f[0]}, aw, low);
        @(posedge clk_g); #1;
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0100;
        aw = 0;
        @(negedge clk_g);
        while (!rd_rdy && aw < WAIT_BOUND) begin @(negedge clk_g); aw++; end
        @(posedge clk_g); #1;
        rd_req = 1'b0;
        seen = 0; cyc = 0; b1 = 'x;
        while (seen < 2 && cyc < 10) begin
            @(negedge clk_g); cyc++;
            if (ret_valid) begin
                if (seen == 1) b1 = ret_data;
                seen++;
            end
        end
        n_tests++; if (b1 !== f[1]) begin n_fail++; $display("FAIL mid_beat1_data: got %h want %h", b1, f[1]); end
        #1 resetn = 1'b0;
        #1;
        n_tests++; if (ret_valid !== 1'b0 || ret_last !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ret: got valid %b last %b want 0/0", ret_valid, ret_last); end
        n_tests++; if (rd_rdy !== 1'b0 || wr_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rdy: got rd %b wr %b want 0/0", rd_rdy, wr_rdy); end
        @(negedge clk_g);
        #2 resetn = 1'b1;
        @(negedge clk_g);
        n_tests++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_release_rdy: got rd %b wr %b want 1/1", rd_rdy, wr_rdy); end
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_g);
            if (ret_valid || ret_last) stale++;
        end
        n_tests++; if (stale !== 0) begin n_fail++; $display("FAIL mid_stale_beats: got %0d want 0", stale); end
        // RAM contents survive reset.
        do_read(3'b100, 32'h0000_0108);
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rb_beats[i] !== f[i]) begin n_fail++; $display("FAIL mid_retained[%0d]: got %h want %h", i, rb_beats[i], f[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_line_write_read();
        test_same_cycle();
        test_byte_strobe();
        test_zero_strobe();
        test_alias();
        test_reset_mid_burst();
        repeat (2) @(posedge clk_g);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
